// File: rtl/phi_state_scheduler.sv
// phi_state_scheduler: walks a small program table of (state, dwell, last)
// segments. It drives state_select to the neural processor for each segment's
// dwell, counted in tick_en pulses, and emits a decimated sample strobe.
module phi_state_scheduler #(
  parameter int unsigned NUM_SEG    = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned DECIM      = 4,
  parameter logic [2:0]  IDLE_STATE = 3'd0,
  localparam int unsigned SEG_W     = $clog2(NUM_SEG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               cfg_we,
  input  logic [SEG_W-1:0]   cfg_addr,
  input  logic [2:0]         cfg_state,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_last,
  input  logic               start,
  input  logic               abort,
  output logic [2:0]         state_select,
  output logic [SEG_W-1:0]   seg_idx,
  output logic               seg_change,
  output logic               busy,
  output logic               done,
  output logic               sample_strobe,
  output logic [15:0]        sample_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  // Program table, one field per array.
  logic [2:0]         r_tab_state [NUM_SEG];
  logic [DWELL_W-1:0] r_tab_dwell [NUM_SEG];
  logic [NUM_SEG-1:0] r_tab_last;

  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [7:0]         r_dec;
  logic [2:0]         r_state_sel;
  logic [SEG_W-1:0]   r_seg_idx;
  logic               r_seg_change;
  logic               r_busy;
  logic               r_done;
  logic               r_strobe;
  logic [15:0]        r_count;
  logic               r_cfg_err;

  logic [2:0]         w_e_state;
  logic [DWELL_W-1:0] w_e_dwell;
  logic               w_e_last;
  logic               w_in_prog;
  logic               w_start_ok;
  logic               w_final_seg;
  logic               w_seg_end;

  // Current entry is read combinationally; writes are locked out while it is in use.
  assign w_e_state   = r_tab_state[r_seg_idx];
  assign w_e_dwell   = r_tab_dwell[r_seg_idx];
  assign w_e_last    = r_tab_last[r_seg_idx];
  assign w_in_prog   = (r_state == S_LOAD) || (r_state == S_RUN);
  assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
  assign w_final_seg = w_e_last || (r_seg_idx == SEG_W'(NUM_SEG - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    w_next    = r_state;
    w_seg_end = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: if (w_e_dwell != '0) w_next = S_RUN;
              else                 w_seg_end = 1'b1;
      S_RUN:  if (tick_en && (r_dwell_cnt == DWELL_W'(1))) w_seg_end = 1'b1;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_seg_end) w_next = w_final_seg ? S_DONE : S_LOAD;
    if (abort)     w_next = S_IDLE;
  end

  // Program table storage: writes only while the program is not executing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: this storage is reset on purpose: an unprogrammed entry must read as an empty final segment.
      for (int i = 0; i < NUM_SEG; i++) begin
        r_tab_state[i] <= 3'd0;
        r_tab_dwell[i] <= '0;
        r_tab_last[i]  <= 1'b1;
      end
    end else if (cfg_we && !w_in_prog) begin
      r_tab_state[cfg_addr] <= cfg_state;
      r_tab_dwell[cfg_addr] <= cfg_dwell;
      r_tab_last[cfg_addr]  <= cfg_last;
    end
  end

  // Segment sequencing: state_select, seg_idx, dwell counter and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_sel  <= IDLE_STATE;
      r_seg_idx    <= '0;
      r_seg_change <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dwell_cnt  <= '0;
    end else begin
      r_seg_change <= 1'b0;
      r_busy       <= (w_next == S_LOAD) || (w_next == S_RUN);
      r_done       <= (w_next == S_DONE);
      if (abort) begin
        r_state_sel <= IDLE_STATE;
      end else begin
        case (r_state)
          S_IDLE: if (start) r_seg_idx <= '0;
          S_LOAD: if (w_e_dwell != '0) begin
                    r_state_sel  <= w_e_state;
                    r_seg_change <= 1'b1;
                    r_dwell_cnt  <= w_e_dwell;
                  end
          S_RUN:  if (tick_en) r_dwell_cnt <= r_dwell_cnt - 1'b1;
          S_DONE: r_state_sel <= IDLE_STATE;
          default: ;
        endcase
        if (w_seg_end && (w_next == S_LOAD)) r_seg_idx <= r_seg_idx + 1'b1;
      end
    end
  end

  // Decimator and sticky config-error flag; both restart with an accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dec     <= '0;
      r_strobe  <= 1'b0;
      r_count   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_start_ok) begin
        r_dec     <= '0;
        r_count   <= '0;
        r_cfg_err <= 1'b0;
      end else begin
        if (!abort && w_in_prog && tick_en) begin
          if (r_dec == 8'(DECIM - 1)) begin
            r_dec    <= '0;
            r_strobe <= 1'b1;
            if (r_count != 16'hFFFF) r_count <= r_count + 1'b1;
          end else begin
            r_dec <= r_dec + 1'b1;
          end
        end
        if (cfg_we && w_in_prog) r_cfg_err <= 1'b1;
      end
    end
  end

  assign state_select  = r_state_sel;
  assign seg_idx       = r_seg_idx;
  assign seg_change    = r_seg_change;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sample_strobe = r_strobe;
  assign sample_count  = r_count;
  assign cfg_err       = r_cfg_err;

endmodule

// File: doc/phi_state_scheduler.md
PHI_STATE_SCHEDULER -- requirements
Module: phi_state_scheduler

Interface
REQ-001 Parameter NUM_SEG, 8: number of program-table entries (power of two).
REQ-002 Parameter DWELL_W, 16: dwell counter width, in tick_en ticks.
REQ-003 Parameter DECIM, 4: tick_en ticks per sample_strobe (legal range 1..255).
REQ-004 Parameter IDLE_STATE, 3'd0: state_select value driven when not running (NORMAL).
REQ-005 Ports: clk  in  1  system clock; the block uses one clock.
REQ-006 Ports: rst  in  1  reset, synchronous, active-low.
REQ-007 Ports: tick_en  in  1  4 kHz clock-enable pulse, one clk wide.
REQ-008 Ports: cfg_we  in  1  program-table write strobe.
REQ-009 Ports: cfg_addr  in  log2(NUM_SEG)  table entry index.
REQ-010 Ports: cfg_state  in  3  state code for the entry.
REQ-011 Ports: cfg_dwell  in  DWELL_W  dwell length in ticks.
REQ-012 Ports: cfg_last  in  1  marks the entry as the final segment.
REQ-013 Ports: start  in  1  run-program request, level-sampled.
REQ-014 Ports: abort  in  1  immediate stop.
REQ-015 Ports: state_select  out  3  state code to the neural processor.
REQ-016 Ports: seg_idx  out  log2(NUM_SEG)  current segment.
REQ-017 Ports: seg_change  out  1  one-cycle pulse when state_select is loaded.
REQ-018 Ports: busy  out  1  high in LOAD and RUN.
REQ-019 Ports: done  out  1  one-cycle completion pulse.
REQ-020 Ports: sample_strobe  out  1  one-cycle capture pulse.
REQ-021 Ports: sample_count  out  16  strobes issued since start.
REQ-022 Ports: cfg_err  out  1  sticky flag for a write while busy.

Function
REQ-023 FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
REQ-024 IDLE + start (abort low) -> LOAD on the next cycle.
- Effects: seg_idx=0; sample_count, decimator and cfg_err cleared.
REQ-025 LOAD, single cycle, entry e = table[seg_idx]:
- e.dwell != 0: state_select <= e.state, seg_change pulses, dwell_cnt <= e.dwell, next state RUN.
- e.dwell == 0: segment skipped, no seg_change; advance per REQ-027.
REQ-026 RUN: each tick_en decrements dwell_cnt. In LOAD, tick_en does not touch dwell_cnt but still feeds the decimator.
REQ-027 Segment end: tick_en with dwell_cnt==1, or a skipped segment.
- e.last=1 or seg_idx==NUM_SEG-1: next state DONE.
- Otherwise: seg_idx+1, next state LOAD.
REQ-028 DONE, single cycle: done=1, state_select <= IDLE_STATE, next state IDLE.
REQ-029 Latency: start at cycle N -> busy=1 at N+1 -> state_select and seg_change valid at N+2.
REQ-030 Segment of dwell D occupies exactly D tick_en pulses in RUN.
REQ-031 Decimator (LOAD/RUN only): counts tick_en.
- On the DECIM-th tick: sample_strobe=1 the following cycle, counter resets.
- sample_count increments per strobe and saturates at 16'hFFFF.
REQ-032 Decimator holds its value across segment boundaries; it is not reset per segment.
REQ-033 cfg_we in IDLE/DONE writes the entry on the same edge.
REQ-034 cfg_we in LOAD/RUN: write discarded, cfg_err set until the next accepted start.
REQ-035 start while busy is ignored.
REQ-036 abort in any state -> IDLE next cycle.
- Effects: state_select=IDLE_STATE, busy=0, no done pulse, no sample_strobe.
- abort wins over simultaneous start.
REQ-037 Table reads are combinational from registered storage. A write in the same cycle as LOAD of the same entry is impossible per REQ-034.

Reset
REQ-038 rst low at a clk edge puts the FSM in IDLE.
- Outputs: state_select=IDLE_STATE; seg_idx, seg_change, busy, done, sample_strobe, sample_count, cfg_err all 0.
REQ-039 Table contents after reset: state=0, dwell=0, last=1 for every entry. start with an unprogrammed table -> DONE within 3 cycles.
REQ-040 Reset mid-run takes effect on the next edge regardless of tick_en.

Verification
REQ-041 Program {0,2000}, {4,3000}, {0,2000,last}, start; DECIM=4.
- state_select sequence 0 -> 4 -> 0; seg_change x3.
- done exactly 7000 ticks after the first RUN cycle.
- sample_count=1750.
REQ-042 Entry1 dwell=0, 3-entry program.
- seg_idx steps 0 -> 2; two seg_change pulses; total ticks = dwell0 + dwell2.
REQ-043 abort at tick 500 of segment 1.
- Next cycle: state_select=0, busy=0, done never pulses; a later start restarts at seg_idx=0.
REQ-044 cfg_we during RUN: cfg_err=1, entry unchanged after run; cfg_err=0 after the next start.
REQ-045 Edge checks:
- start and abort together in IDLE -> stays IDLE.
- rst low during RUN -> all outputs at reset values next cycle.
- 8 entries with no last flag -> DONE after entry 7.
